mlaccel_memory_rot: RTL and testbench

Parametrised byte-addressable accelerator memory built from LANES byte-wide banks. Performs unaligned reads and unaligned, byte-strobed writes of up to LANES bytes starting at any byte address, with address wrap-around. Adds a valid/ready request port and a backpressured response FIFO. Sits between the accelerator sequencer and the on-chip RAM, replacing the fixed 4-lane, unhandshaked memory.

---
 rtl/mlaccel_pkg.sv | 39 +++
 rtl/mlaccel_memory_bank.sv | 27 ++
 rtl/mlaccel_memory_rot.sv | 130 +++++++++++++
 tb/tb_mlaccel_memory_rot.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_pkg.sv
// Shared accelerator helpers.
//   clog2       : ceiling log2 for parameter derivation
//   lane_bits   : log2 of the lane count (byte offset width inside a row)
//   row_count   : rows per bank for a given byte address width and lane count
//   rotr_bytes  : rotate the low `lanes` bytes of a word right by `sh` bytes
//                 (byte k of the result = byte (k+sh) mod lanes of the input)
package mlaccel_pkg;

  localparam int MAX_LANES = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int lane_bits(input int lanes);
    return clog2(lanes);
  endfunction

  function automatic int row_count(input int addr_bits, input int lanes);
    return (1 << addr_bits) / lanes;
  endfunction

  function automatic logic [8*MAX_LANES-1:0] rotr_bytes(
    input logic [8*MAX_LANES-1:0] d,
    input int                     lanes,
    input int                     sh
  );
    logic [8*MAX_LANES-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_LANES; k++)
      if (k < lanes) r[8*k +: 8] = d[8*((k + sh) % lanes) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mlaccel_memory_bank.sv
// One byte-wide memory bank, ROWS deep.
//   clock : rising-edge clock
//   we    : write enable for wdata at addr
//   addr  : row address (read and write share it)
//   wdata : write byte
//   rdata : registered read byte, valid the cycle after addr is presented
// Written in the inferable single-port form so the tools can map it onto
// SPRAM halves where the target has them. Contents are never reset.
module mlaccel_memory_bank #(
  parameter int ROWS     = 32768,
  parameter int ROW_BITS = 15
) (
  input  logic                clock,
  input  logic                we,
  input  logic [ROW_BITS-1:0] addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata
);

  logic [7:0] mem [ROWS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mlaccel_memory_rot.sv
// Byte-addressable accelerator memory: LANES byte banks, unaligned reads and
// byte-strobed unaligned writes with address wrap, valid/ready request port
// and a credit-protected response FIFO.
//   clock, reset          : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_addr              : start byte address
//   req_wen               : 1 = write, 0 = read
//   req_wstrb/req_wdata   : byte k -> address req_addr+k when wstrb[k]
//   rsp_valid/rsp_ready   : response FIFO head handshake
//   rsp_data              : byte k = mem[req_addr+k] of the matching read
import mlaccel_pkg::*;

module mlaccel_memory_rot #(
  parameter int LANES     = 4,
  parameter int ADDR_BITS = 17,
  parameter int RSP_DEPTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic                 req_wen,
  input  logic [LANES-1:0]     req_wstrb,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*LANES-1:0]   rsp_data
);

  localparam int LB       = lane_bits(LANES);
  localparam int ROW_BITS = ADDR_BITS - LB;
  localparam int ROWS     = row_count(ADDR_BITS, LANES);
  localparam int CW       = clog2(RSP_DEPTH + 1);
  localparam int PW       = clog2(RSP_DEPTH);
  localparam int STAGES   = 1;

  logic                 accept;
  logic [LB-1:0]        lo;
  logic [LB-1:0]        lo_q;
  logic [STAGES:1]      vld_q;
  logic [STAGES:0]      vld_pipe;
  logic [LANES-1:0][7:0] bank_q;
  logic [8*MAX_LANES-1:0] rot_full;
  logic [8*LANES-1:0]   rot_w;

  logic [8*LANES-1:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [CW:0]          occ;
  logic [8*LANES-1:0]   hold_q;
  logic                 push, pop;

  // Credits: a read in the bank stage already owns a FIFO slot, so the
  // slot count never overflows even while rsp_ready is low.
  assign occ       = (CW+1)'(count) + (CW+1)'(vld_pipe[STAGES]);
  assign req_ready = !reset && (occ < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign lo        = req_addr[LB-1:0];

  // vld_pipe[0] is the read accepted this edge; higher bits are in flight.
  assign vld_pipe = {vld_q, accept && !req_wen};

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      lo_q  <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (accept) lo_q <= lo;
    end
  end

  // Bank b serves byte k = b - lo; banks below the offset start on the next
  // row, and the row add wraps naturally at ROWS.
  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [LB-1:0]       k;
    logic [ROW_BITS-1:0] row;
    assign k   = LB'(b) - lo;
    assign row = req_addr[ADDR_BITS-1:LB] + ROW_BITS'((LB'(b) < lo) ? 1 : 0);

    mlaccel_memory_bank #(.ROWS(ROWS), .ROW_BITS(ROW_BITS)) u_bank (
      .clock (clock),
      .we    (accept && req_wen && req_wstrb[k]),
      .addr  (row),
      .wdata (req_wdata[8*k +: 8]),
      .rdata (bank_q[b])
    );
  end

  assign rot_full = rotr_bytes((8*MAX_LANES)'(bank_q), LANES, int'(lo_q));
  assign rot_w    = rot_full[8*LANES-1:0];

  if (LANES < MAX_LANES) begin : g_rot_hi
    logic unused_hi;
    assign unused_hi = ^rot_full[8*MAX_LANES-1:8*LANES];
  end

  // Response FIFO
  assign push      = vld_pipe[STAGES];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  // Once drained the output keeps showing the last popped word.
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : hold_q;

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= rot_w;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
        hold_q <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mlaccel_memory_rot.sv
module tb_mlaccel_memory_rot;

  localparam int LANES     = 4;
  localparam int ADDR_BITS = 17;
  localparam int RSP_DEPTH = 3;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr = '0;
  logic                 req_wen = 1'b0;
  logic [LANES-1:0]     req_wstrb = '0;
  logic [8*LANES-1:0]   req_wdata = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [8*LANES-1:0]   rsp_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  mlaccel_memory_rot #(.LANES(LANES), .ADDR_BITS(ADDR_BITS), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte at address a in the preload pattern is a + 0x40.
  function automatic logic [31:0] pat(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(a + k + 64);
    return w;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_rdy"}, 64'(req_ready), 64'd1);
  endtask

  task automatic write_req(input logic [ADDR_BITS-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input string tag);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    wait_ready(tag);
    step();
    req_valid = 1'b0; req_wen = 1'b0; req_wstrb = '0;
  endtask

  task automatic read_req(input logic [ADDR_BITS-1:0] a, input logic [31:0] exp,
                          input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a;
    wait_ready(tag);
    step();
    req_valid = 1'b0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    check(tag, {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, exp});
    step();
  endtask

  // Issue n reads at base..base+n-1; rsp_ready held low for the first
  // `hold` cycles. Every popped word is checked in order.
  task automatic stream(input int n, input int base, input int hold, input string tag);
    int idx = 0, got = 0, cyc = 0, first = -1, last = -1, stalls = 0;
    logic rdy, pp;
    logic [31:0] d;
    rsp_ready = (hold == 0);
    while ((idx < n || got < n) && cyc < 200) begin
      if (cyc == hold && hold > 0) begin
        check({tag, "_accepted_before_release"}, 64'(idx), 64'd3);
        check({tag, "_ready_low_when_full"}, 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
      end
      req_valid = (idx < n); req_wen = 1'b0; req_addr = ADDR_BITS'(base + idx);
      rdy = req_ready; pp = rsp_valid && rsp_ready; d = rsp_data;
      if (req_valid && !rdy) stalls++;
      step();
      if (req_valid && rdy) idx++;
      if (pp) begin
        check($sformatf("%s_rsp%0d", tag, got), 64'(d), 64'(pat(base + got)));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      cyc++;
    end
    req_valid = 1'b0;
    check({tag, "_accepted"}, 64'(idx), 64'(n));
    check({tag, "_responses"}, 64'(got), 64'(n));
    if (hold == 0) begin
      check({tag, "_stalls"}, 64'(stalls), 64'd0);
      check({tag, "_first_rsp_cycle"}, 64'(first), 64'd2);
      check({tag, "_last_rsp_cycle"}, 64'(last), 64'(n + 1));
    end
    step(); step();
    check({tag, "_no_extra"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic seen;

    // Reset state
    step(); step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // Aligned writes, unaligned read with latency check
    write_req(17'd0, 32'h03020100, 4'hF, "w0");
    write_req(17'd4, 32'h07060504, 4'hF, "w4");
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 17'd3;
    check("rd3_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check("rd3_not_yet", 64'(rsp_valid), 64'd0);
    step();
    check("rd3_data", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'h06050403});
    step();
    check("rd3_popped", 64'(rsp_valid), 64'd0);
    check("rd3_hold", 64'(rsp_data), 64'h06050403);

    // Wrap-around write across the top of memory
    write_req(17'h1FFFF, 32'hDDCCBBAA, 4'hF, "wwrap");
    read_req(17'd0, 32'h03DDCCBB, "rd_wrap0");
    read_req(17'h1FFFF, 32'hDDCCBBAA, "rd_wrap_top");

    // Partial strobes: bytes k=0 and k=2 land at 9 and 11
    write_req(17'd8, 32'h44332211, 4'hF, "w8");
    write_req(17'd9, 32'hFFFFFFFF, 4'b0101, "w9s");
    read_req(17'd8, 32'hFF33FF11, "rd_strb");
    write_req(17'd8, 32'hAAAAAAAA, 4'b0000, "w8_nostrb");
    read_req(17'd8, 32'hFF33FF11, "rd_nostrb");

    // Pattern preload for the streaming tests
    for (int a = 0; a <= 20; a += 4) write_req(ADDR_BITS'(a), pat(a), 4'hF, "wpat");

    stream(5, 0, 6, "bp");
    stream(16, 0, 0, "stream");

    // Reset with two reads outstanding and a write presented during reset
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 17'd0;
    check("rr_ready0", 64'(req_ready), 64'd1);
    step();
    req_addr = 17'd4;
    check("rr_ready1", 64'(req_ready), 64'd1);
    step();
    reset = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 17'd0;
    req_wdata = 32'hEEEEEEEE; req_wstrb = 4'hF;
    #1;
    check("rr_ready_in_reset", 64'(req_ready), 64'd0);
    step();
    check("rr_valid_in_reset", 64'(rsp_valid), 64'd0);
    check("rr_data_in_reset", 64'(rsp_data), 64'd0);
    step();
    reset = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_wstrb = '0;
    rsp_ready = 1'b1;
    #1;
    check("rr_ready_after", 64'(req_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1'b1;
      step();
    end
    check("rr_no_stale", 64'(seen), 64'd0);
    read_req(17'd0, pat(0), "rr_data_kept0");
    read_req(17'd4, pat(4), "rr_data_kept4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
